// File: rtl/snn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_ctrl_pkg
// Brief    : Shared state encoding and default widths for the SNN time-step
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package snn_ctrl_pkg;

  localparam int c_default_div_w  = 8;
  localparam int c_default_step_w = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/flag_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : flag_sync_edge
// Brief    : Multi-flop synchroniser for a slow asynchronous flag, followed by
//            a rise/fall edge detector in the destination clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module flag_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flag,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  // Fills with ones after reset; edges are only reported once r_prev holds a
  // genuine sample, so a flag already high across reset is not seen as a rise.
  logic [SYNC_STAGES:0]   r_vld;

  // Synchroniser chain, edge-detect history and post-reset priming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_vld  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], flag};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = r_vld[SYNC_STAGES] &  level & ~r_prev;
  assign fall  = r_vld[SYNC_STAGES] & ~level &  r_prev;

endmodule
`default_nettype wire

// File: rtl/snn_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : snn_step_controller
// Brief    : Synchronises SPI ready flags, latches the clock divider and
//            issues the neuron/delay pipeline time-step strobe.
// Revision : 1.0 - initial release
// ============================================================================
module snn_step_controller
  import snn_ctrl_pkg::*;
#(
  parameter int DIV_W       = c_default_div_w,
  parameter int STEP_W      = c_default_step_w,
  parameter int MAX_STEPS   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_div_ready,
  input  logic              input_spike_ready,
  input  logic [DIV_W-1:0]  clk_div_cfg,
  output logic              step_en,
  output logic [STEP_W-1:0] step_count,
  output logic              running,
  output logic              done,
  output logic [DIV_W-1:0]  div_value
);

  localparam logic [STEP_W-1:0] c_max_steps = STEP_W'(MAX_STEPS);
  localparam bit                c_limited   = (MAX_STEPS != 0);

  logic w_div_level, w_div_rise, w_div_fall;
  logic w_spk_level, w_spk_rise, w_spk_fall;
  logic w_unused;

  state_e             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [STEP_W-1:0]  r_step_count, w_step_count_nxt, w_step_inc;
  logic               w_step;
  logic               r_running, r_done;

  flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_div_sync (
    .clk   (clk),
    .reset (reset),
    .flag  (clk_div_ready),
    .level (w_div_level),
    .rise  (w_div_rise),
    .fall  (w_div_fall)
  );

  flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_spk_sync (
    .clk   (clk),
    .reset (reset),
    .flag  (input_spike_ready),
    .level (w_spk_level),
    .rise  (w_spk_rise),
    .fall  (w_spk_fall)
  );

  // The spike flag is acted on by level and the divider flag by edge only.
  assign w_unused   = &{1'b0, w_div_level, w_spk_rise, w_spk_fall};
  assign w_step_inc = r_step_count + 1'b1;

  // Next-state logic; divider-flag fall outranks spike-flag loss, which
  // outranks the terminal step count.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_div_nxt        = r_div;
    w_step_count_nxt = r_step_count;
    w_step           = 1'b0;
    if (w_div_fall) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_div_rise) begin
            w_div_nxt   = clk_div_cfg;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_div_rise) begin
            w_div_nxt = clk_div_cfg;
            w_cnt_nxt = '0;
          end else if (w_spk_level) begin
            w_state_nxt      = ST_RUN;
            w_cnt_nxt        = '0;
            w_step_count_nxt = '0;
          end
        end
        ST_RUN: begin
          if (!w_spk_level) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else if (w_div_rise) begin
            w_div_nxt = clk_div_cfg;
            w_cnt_nxt = '0;
          end else if (r_cnt == r_div) begin
            w_step           = 1'b1;
            w_cnt_nxt        = '0;
            w_step_count_nxt = w_step_inc;
            if (c_limited && (w_step_inc == c_max_steps)) begin
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!w_spk_level) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else if (w_div_rise) begin
            w_div_nxt = clk_div_cfg;
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters, divider latch and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_div        <= '0;
      r_step_count <= '0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_div        <= w_div_nxt;
      r_step_count <= w_step_count_nxt;
      r_running    <= (w_state_nxt == ST_RUN);
      r_done       <= (w_state_nxt == ST_DONE);
    end
  end

  assign step_en    = w_step;
  assign step_count = r_step_count;
  assign running    = r_running;
  assign done       = r_done;
  assign div_value  = r_div;

endmodule
`default_nettype wire

// File: tb/tb_snn_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_step_controller
// Brief    : Directed self-checking bench for snn_step_controller; a second
//            instance with a step limit of 5 shares the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_step_controller;

  logic        clk;
  logic        reset;
  logic        clk_div_ready;
  logic        input_spike_ready;
  logic [7:0]  clk_div_cfg;

  logic        step_en,    m_step_en;
  logic [15:0] step_count, m_step_count;
  logic        running,    m_running;
  logic        done,       m_done;
  logic [7:0]  div_value,  m_div_value;

  int checks;
  int failures;

  snn_step_controller #(.DIV_W(8), .STEP_W(16), .MAX_STEPS(0), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .clk_div_ready     (clk_div_ready),
    .input_spike_ready (input_spike_ready),
    .clk_div_cfg       (clk_div_cfg),
    .step_en           (step_en),
    .step_count        (step_count),
    .running           (running),
    .done              (done),
    .div_value         (div_value)
  );

  snn_step_controller #(.DIV_W(8), .STEP_W(16), .MAX_STEPS(5), .SYNC_STAGES(2)) dut_max (
    .clk               (clk),
    .reset             (reset),
    .clk_div_ready     (clk_div_ready),
    .input_spike_ready (input_spike_ready),
    .clk_div_cfg       (clk_div_cfg),
    .step_en           (m_step_en),
    .step_count        (m_step_count),
    .running           (m_running),
    .done              (m_done),
    .div_value         (m_div_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset             = 1'b0;
    clk_div_ready     = 1'b0;
    input_spike_ready = 1'b0;
    clk_div_cfg       = 8'd0;
    tick(2);
    reset = 1'b1;
    tick(4);
  endtask

  // Leaves the bench one sample point after the RUN entry edge.
  task automatic start_run(input logic [7:0] cfg);
    do_reset();
    clk_div_cfg   = cfg;
    clk_div_ready = 1'b1;
    tick(4);
    input_spike_ready = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    reset             = 1'b0;
    clk_div_ready     = 1'b0;
    input_spike_ready = 1'b0;
    clk_div_cfg       = 8'd0;
    #1;
    checks++;
    if ({step_en, step_count, running, done, div_value, m_step_en, m_step_count, m_running, m_done, m_div_value} !== '0) begin
      failures++;
      $display("FAIL reset_values: got %0b %0d %0b %0b %0d, want all zero", step_en, step_count, running, done, div_value);
    end
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({step_en, step_count, running, done, div_value} !== '0) begin
        failures++;
        $display("FAIL idle_quiet cycle %0d: got %0b %0d %0b %0b %0d, want all zero", i, step_en, step_count, running, done, div_value);
      end
    end
  endtask

  task automatic test_div3_steps();
    do_reset();
    clk_div_cfg   = 8'd3;
    clk_div_ready = 1'b1;
    tick(2);
    checks++;
    if (div_value !== 8'd0) begin
      failures++;
      $display("FAIL div_early: got %0d want 0", div_value);
    end
    tick(2);
    checks++;
    if (div_value !== 8'd3 || running !== 1'b0) begin
      failures++;
      $display("FAIL div_load: got div %0d run %0b want div 3 run 0", div_value, running);
    end
    input_spike_ready = 1'b1;
    tick(2);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL run_early: got %0b want 0", running);
    end
    tick();
    checks++;
    if (running !== 1'b1 || step_count !== 16'd0) begin
      failures++;
      $display("FAIL run_entry: got run %0b cnt %0d want run 1 cnt 0", running, step_count);
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (step_en !== (i % 4 == 3) || step_count !== 16'(i / 4)) begin
        failures++;
        $display("FAIL div3_step i=%0d: got en %0b cnt %0d want en %0b cnt %0d", i, step_en, step_count, (i % 4 == 3), i / 4);
      end
      tick();
    end
    checks++;
    if (step_count !== 16'd10) begin
      failures++;
      $display("FAIL div3_total: got %0d want 10", step_count);
    end
  endtask

  task automatic test_div0_and_drop();
    start_run(8'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (step_en !== 1'b1 || step_count !== 16'(i)) begin
        failures++;
        $display("FAIL div0_step i=%0d: got en %0b cnt %0d want en 1 cnt %0d", i, step_en, step_count, i);
      end
      tick();
    end
    input_spike_ready = 1'b0;
    tick(2);
    checks++;
    if (step_en !== 1'b0 || running !== 1'b1 || step_count !== 16'd10) begin
      failures++;
      $display("FAIL drop_transition: got en %0b run %0b cnt %0d want en 0 run 1 cnt 10", step_en, running, step_count);
    end
    tick();
    checks++;
    if (running !== 1'b0 || step_count !== 16'd10) begin
      failures++;
      $display("FAIL drop_armed: got run %0b cnt %0d want run 0 cnt 10", running, step_count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (step_en !== 1'b0 || step_count !== 16'd10) begin
        failures++;
        $display("FAIL armed_frozen i=%0d: got en %0b cnt %0d want en 0 cnt 10", i, step_en, step_count);
      end
    end
  endtask

  task automatic test_max_steps();
    int exp_cnt;
    start_run(8'd2);
    for (int i = 0; i < 25; i++) begin
      exp_cnt = (i / 3 > 5) ? 5 : i / 3;
      checks++;
      if (m_step_en !== (i < 15 && i % 3 == 2) || m_step_count !== 16'(exp_cnt) ||
          m_done !== (i >= 15) || m_running !== (i < 15)) begin
        failures++;
        $display("FAIL max_run i=%0d: got en %0b cnt %0d done %0b run %0b want en %0b cnt %0d done %0b run %0b",
                 i, m_step_en, m_step_count, m_done, m_running, (i < 15 && i % 3 == 2), exp_cnt, (i >= 15), (i < 15));
      end
      tick();
    end
    checks++;
    if (running !== 1'b1 || step_count !== 16'd8) begin
      failures++;
      $display("FAIL unlimited_run: got run %0b cnt %0d want run 1 cnt 8", running, step_count);
    end
    input_spike_ready = 1'b0;
    tick(3);
    checks++;
    if (m_done !== 1'b0 || m_running !== 1'b0 || m_step_count !== 16'd5) begin
      failures++;
      $display("FAIL done_to_armed: got done %0b run %0b cnt %0d want 0 0 5", m_done, m_running, m_step_count);
    end
    input_spike_ready = 1'b1;
    tick(3);
    checks++;
    if (m_running !== 1'b1 || m_step_count !== 16'd0) begin
      failures++;
      $display("FAIL rerun_start: got run %0b cnt %0d want run 1 cnt 0", m_running, m_step_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_step_en !== (i == 2) || m_step_count !== 16'(i / 3)) begin
        failures++;
        $display("FAIL rerun_step i=%0d: got en %0b cnt %0d want en %0b cnt %0d", i, m_step_en, m_step_count, (i == 2), i / 3);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous_drop();
    start_run(8'd1);
    tick(3);
    checks++;
    if (step_en !== 1'b1) begin
      failures++;
      $display("FAIL sim_pre_step: got %0b want 1", step_en);
    end
    clk_div_ready     = 1'b0;
    input_spike_ready = 1'b0;
    tick(2);
    checks++;
    if (step_en !== 1'b0) begin
      failures++;
      $display("FAIL sim_no_extra_step: got %0b want 0", step_en);
    end
    tick();
    checks++;
    if (running !== 1'b0 || done !== 1'b0 || step_count !== 16'd2) begin
      failures++;
      $display("FAIL sim_idle: got run %0b done %0b cnt %0d want 0 0 2", running, done, step_count);
    end
    input_spike_ready = 1'b1;
    tick(6);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL sim_not_armed: got run %0b want 0", running);
    end
    clk_div_cfg   = 8'd7;
    clk_div_ready = 1'b1;
    tick(2);
    checks++;
    if (div_value !== 8'd1) begin
      failures++;
      $display("FAIL reload_early: got %0d want 1", div_value);
    end
    tick();
    checks++;
    if (div_value !== 8'd7 || running !== 1'b0) begin
      failures++;
      $display("FAIL reload_div7: got div %0d run %0b want div 7 run 0", div_value, running);
    end
    tick();
    checks++;
    if (running !== 1'b1 || step_count !== 16'd0) begin
      failures++;
      $display("FAIL reload_run: got run %0b cnt %0d want run 1 cnt 0", running, step_count);
    end
  endtask

  task automatic test_async_reset();
    start_run(8'd3);
    tick(5);
    checks++;
    if (running !== 1'b1 || step_count !== 16'd1 || div_value !== 8'd3) begin
      failures++;
      $display("FAIL pre_reset_run: got run %0b cnt %0d div %0d want 1 1 3", running, step_count, div_value);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({step_en, step_count, running, done, div_value} !== '0) begin
      failures++;
      $display("FAIL async_reset: got %0b %0d %0b %0b %0d want all zero", step_en, step_count, running, done, div_value);
    end
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (running !== 1'b0 || div_value !== 8'd0 || step_en !== 1'b0) begin
        failures++;
        $display("FAIL held_level_no_load i=%0d: got run %0b div %0d en %0b want 0 0 0", i, running, div_value, step_en);
      end
    end
    clk_div_ready = 1'b0;
    tick(4);
    clk_div_cfg   = 8'd5;
    clk_div_ready = 1'b1;
    tick(3);
    checks++;
    if (div_value !== 8'd5) begin
      failures++;
      $display("FAIL fresh_edge_load: got %0d want 5", div_value);
    end
    tick();
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL fresh_edge_run: got %0b want 1", running);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_div3_steps();
    test_div0_and_drop();
    test_max_steps();
    test_simultaneous_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
